// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width,
// funct3 encodings and FSM state encoding.
package rv32m_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/busy/done request bus between the control unit and the mul/div unit.
interface mul_div_unit_if;

    logic                       start;
    logic [2:0]                 funct3;
    logic [rv32m_pkg::XLEN-1:0] operand_a;
    logic [rv32m_pkg::XLEN-1:0] operand_b;
    logic                       busy;
    logic                       done;
    logic [rv32m_pkg::XLEN-1:0] result;

    modport master (output start, funct3, operand_a, operand_b,
                    input  busy, done, result);
    modport slave  (input  start, funct3, operand_a, operand_b,
                    output busy, done, result);

endinterface

// File: rtl/mul_div_step.sv
// One iteration of either shift-add multiply (accumulate the gated operand)
// or restoring divide (trial-subtract divisor from the shifted remainder).
module mul_div_step
    import rv32m_pkg::*;
(
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [2*XLEN-1:0] i_opnd,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_qbit
);

    logic [XLEN:0] w_diff;
    logic          w_qbit;

    assign w_diff = i_acc[XLEN:0] - i_opnd[XLEN:0];
    assign w_qbit = ~w_diff[XLEN];

    always_comb begin
        o_qbit = 1'b0;
        o_acc  = i_acc + i_opnd;
        if (i_is_div) begin
            o_qbit = w_qbit;
            o_acc  = (2*XLEN)'(w_qbit ? w_diff : i_acc[XLEN:0]);
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M execute unit: 32-cycle magnitude multiply/divide with
// sign fix-up; div-by-zero and signed overflow bypass the iterations.
module mul_div_unit
    import rv32m_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_sign_a, r_sign_b, r_special;
    logic [2*XLEN-1:0] r_acc, r_mcand;
    logic [XLEN-1:0]   r_a, r_b;
    logic              r_busy, r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_val;
    logic              w_div0, w_ovf, w_is_div;
    logic [2*XLEN-1:0] w_step_acc, w_step_opnd, w_step_nxt;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_val;

    // Operand decode at request time
    assign w_a_signed = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) &&
                        (bus.funct3 != F3_REMU);
    assign w_b_signed = w_a_signed && (bus.funct3 != F3_MULHSU);
    assign w_sign_a   = w_a_signed & bus.operand_a[XLEN-1];
    assign w_sign_b   = w_b_signed & bus.operand_b[XLEN-1];
    assign w_mag_a    = w_sign_a ? -bus.operand_a : bus.operand_a;
    assign w_mag_b    = w_sign_b ? -bus.operand_b : bus.operand_b;
    assign w_div0     = bus.funct3[2] && (bus.operand_b == '0);
    assign w_ovf      = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                        (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (bus.operand_b == '1);
    // REM/REMU have funct3[1] set; DIV/DIVU do not
    assign w_special_val = w_div0 ? (bus.funct3[1] ? bus.operand_a : '1)
                                  : (bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    assign w_is_div    = r_op[2];
    assign w_step_acc  = w_is_div ? (2*XLEN)'({r_acc[XLEN-1:0], r_a[XLEN-1]}) : r_acc;
    assign w_step_opnd = w_is_div ? (2*XLEN)'(r_b) : (r_b[0] ? r_mcand : '0);

    mul_div_step u_step (
        .i_acc    (w_step_acc),
        .i_opnd   (w_step_opnd),
        .i_is_div (w_is_div),
        .o_acc    (w_step_nxt),
        .o_qbit   (w_qbit)
    );

    // Sign correction and result selection
    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_a : r_a;
    assign w_rem  = r_sign_a ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];

    always_comb begin
        w_fix_val = r_acc[XLEN-1:0];
        if (!r_special) begin
            case (r_op)
                F3_MUL:                      w_fix_val = w_prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: w_fix_val = w_prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:             w_fix_val = w_quo;
                default:                     w_fix_val = w_rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_special <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.funct3;
                        r_sign_a  <= w_sign_a;
                        r_sign_b  <= w_sign_b;
                        r_a       <= w_mag_a;
                        r_b       <= w_mag_b;
                        r_mcand   <= (2*XLEN)'(w_mag_a);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_special <= w_div0 || w_ovf;
                        r_acc     <= (w_div0 || w_ovf) ? (2*XLEN)'(w_special_val) : '0;
                        r_state   <= (w_div0 || w_ovf) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step_nxt;
                    if (w_is_div) begin
                        r_a <= {r_a[XLEN-2:0], w_qbit};
                    end else begin
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_val;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, handshake corner sequences,
// and random operations against an arithmetic reference model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit / integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic        [63:0] up;
        int qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(qa % qb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge; returns at the negedge right after the start edge
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.funct3    = f3;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges after the start edge until done; optionally fires ignored starts
    task automatic wait_done(input bit disturb, output logic [31:0] res, output int lat,
                             output bit busy_ok);
        int n = 0;
        busy_ok = 1'b1;
        while (!bus.done && n < 100) begin
            bus.start = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (disturb && n < 30) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.funct3    = 3'($urandom_range(0, 7));
                bus.operand_a = $urandom;
                bus.operand_b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        res = bus.result;
        lat = n;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          bok;
        launch(f3, a, b);
        wait_done(1'b0, res, lat, bok);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy"}, 32'(bok), 32'd1);
    endtask

    initial begin
        logic [31:0] res, ra, rb;
        logic [2:0]  rf;
        int          lat;
        bit          bok, done_seen;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.funct3 = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);

        // Starts fired during CALC must be ignored; a start in the done cycle is taken
        launch(3'd0, 32'd2, 32'd3);
        wait_done(1'b1, res, lat, bok);
        check("ignore result", res, 32'd6);
        check("ignore latency", 32'(lat), 32'd33);
        run_op("b2b divu", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // Reset mid-operation abandons it without a done pulse
        launch(3'd4, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst result", bus.result, 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("midrst no done", 32'(done_seen), 32'd0);
        run_op("post rst mul", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        for (int i = 0; i < 200; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf, ra, rb), rf, ra, rb,
                   ref_op(rf, ra, rb), ref_lat(rf, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
